// File: rtl/dram_sim_model_pkg.sv
// Shared encodings for the DRAM simulation model: request codes, FSM state
// type and the stall-generator LFSR step.
package dram_sim_model_pkg;

    localparam logic [1:0] REQ_NONE  = 2'b00;
    localparam logic [1:0] REQ_READ  = 2'b01;
    localparam logic [1:0] REQ_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/dram_sim_model_rd_pipe.sv
// Read-return delay line: LAT stages of valid/data with synchronous clear.
// o_busy reports data still in flight ahead of the output stage.
module dram_rd_pipe #(
    parameter int W   = 512,
    parameter int LAT = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_vld,
    input  logic [W-1:0] i_data,
    output logic         o_vld,
    output logic [W-1:0] o_data,
    output logic         o_busy
);

    logic [LAT-1:0] r_vld;
    logic [W-1:0]   r_data [LAT];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_vld;
            // Bubbles carry zero so the output bus stays quiet between pulses.
            r_data[0] <= i_vld ? i_data : '0;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    always_comb begin
        o_busy = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            o_busy = o_busy | r_vld[i];
        end
    end

    assign o_vld  = r_vld[LAT-1];
    assign o_data = r_data[LAT-1];

endmodule

// File: rtl/dram_sim_model.sv
// Behavioural DRAM block store with burst read/write and fixed read latency.
// Define DRAM_STALL_EN to inject LFSR-driven stall cycles.
module dram_sim_model
    import dram_sim_model_pkg::*;
#(
    parameter int          DRAMW     = 512,
    parameter int          DEPTH     = 1048576,
    parameter int          ADDR_STEP = 8,
    parameter int          RD_LAT    = 4,
    parameter int          STALL_TH  = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       D_REQ,
    input  logic [31:0]      D_INITADR,
    input  logic [31:0]      D_ELEM,
    input  logic [DRAMW-1:0] D_DIN,
    output logic             D_W,
    output logic [DRAMW-1:0] D_DOUT,
    output logic             D_DOUTEN,
    output logic             D_BUSY,
    output state_t           o_dbg_state
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_BLK = AW'(DEPTH - 1);

    if (RD_LAT < 1 || RD_LAT > 16 || STALL_TH < 0 || STALL_TH > 15 || LFSR_SEED == 16'h0) begin : g_param_check
        $error("dram_sim_model: parameter out of range");
    end

    state_t          r_state;
    logic [31:0]     r_rem;
    logic [AW-1:0]   r_blk;
    logic [DRAMW-1:0] r_mem [DEPTH];

    logic            w_stall;
    logic            w_issue;
    logic            w_pipe_busy;
    logic            w_start;
    logic [AW-1:0]   w_next_blk;

`ifdef DRAM_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge CLK) begin
        if (RST) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= lfsr_next(r_lfsr);
    end

    assign w_stall = ({28'd0, r_lfsr[3:0]} < $unsigned(STALL_TH));
`else
    assign w_stall = 1'b0;
`endif

    assign w_start    = (D_ELEM != 32'd0) && (D_REQ == REQ_READ || D_REQ == REQ_WRITE);
    assign w_next_blk = (r_blk == LAST_BLK) ? '0 : r_blk + 1'b1;

    // Strobes are gated by RST so nothing moves during the reset cycle itself.
    assign D_W     = !RST && (r_state == ST_WRITE) && !w_stall;
    assign w_issue = !RST && (r_state == ST_READ) && !w_stall;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_blk   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= (D_REQ == REQ_READ) ? ST_READ : ST_WRITE;
                        r_rem   <= D_ELEM;
                        r_blk   <= AW'((D_INITADR / $unsigned(ADDR_STEP)) % $unsigned(DEPTH));
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (!w_stall) begin
                        r_rem <= r_rem - 32'd1;
                        r_blk <= w_next_blk;
                        if (r_rem == 32'd1) begin
                            r_state <= (r_state == ST_READ) ? ST_DRAIN : ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave once only the output stage holds data, so BUSY
                    // drops right after the final DOUTEN.
                    if (!w_pipe_busy) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset: contents survive RST.
    always_ff @(posedge CLK) begin
        if (D_W) r_mem[r_blk] <= D_DIN;
    end

    dram_rd_pipe #(
        .W   (DRAMW),
        .LAT (RD_LAT)
    ) u_rd_pipe (
        .CLK    (CLK),
        .RST    (RST),
        .i_vld  (w_issue),
        .i_data (r_mem[r_blk]),
        .o_vld  (D_DOUTEN),
        .o_data (D_DOUT),
        .o_busy (w_pipe_busy)
    );

    assign D_BUSY      = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dram_sim_model.sv
// Self-checking bench for dram_sim_model: directed vector table, reset and
// busy-request sequences, then randomized bursts against an array model.
module tb_dram_sim_model;
    import dram_sim_model_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int STEP  = 8;
    localparam int LAT   = 4;
    localparam int TH    = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic [1:0]   D_REQ;
    logic [31:0]  D_INITADR;
    logic [31:0]  D_ELEM;
    logic [W-1:0] D_DIN;
    logic         D_W;
    logic [W-1:0] D_DOUT;
    logic         D_DOUTEN;
    logic         D_BUSY;
    state_t       dbg_state;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    dram_sim_model #(
        .DRAMW     (W),
        .DEPTH     (DEPTH),
        .ADDR_STEP (STEP),
        .RD_LAT    (LAT),
        .STALL_TH  (TH),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .D_REQ       (D_REQ),
        .D_INITADR   (D_INITADR),
        .D_ELEM      (D_ELEM),
        .D_DIN       (D_DIN),
        .D_W         (D_W),
        .D_DOUT      (D_DOUT),
        .D_DOUTEN    (D_DOUTEN),
        .D_BUSY      (D_BUSY),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] model_mem [DEPTH];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] wbuf[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        int          elem;
        logic [31:0] base;
        int          exp_pulses;
        int          exp_dw;
        int          exp_busy;
        int          intrude;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_min(input string name, input int act, input int min_val);
        n_tests++;
        if (act < min_val) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, min_val);
        end
    endtask

    function automatic int model_blk(input logic [31:0] addr);
        return int'((addr / STEP) % DEPTH);
    endfunction

    // ---------------- driver ----------------
    task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] addr,
                          input int elem, input int exp_pulses, input int exp_dw,
                          input int exp_busy, input int intrude);
        int blk0;
        int k;
        int pulses;
        int busy_cyc;
        int first;
        int cyc;
        int budget;
        bit done;
        blk0 = model_blk(addr);
        k = 0; pulses = 0; busy_cyc = 0; first = -1; cyc = 0; done = 0;
        budget = 8 * elem + 4 * LAT + 20;
        exp_q.delete();
        if (op == REQ_READ) begin
            for (int j = 0; j < elem; j++) exp_q.push_back(model_mem[(blk0 + j) % DEPTH]);
        end
        @(negedge CLK);
        D_REQ = op; D_INITADR = addr; D_ELEM = elem;
        D_DIN = (wbuf.size() > 0) ? wbuf[0] : '0;
        while (!done) begin
            @(negedge CLK);
            cyc++;
            if (intrude > 0 && (cyc == 2 || cyc == 3)) begin
                D_REQ = REQ_READ; D_INITADR = 32'h10; D_ELEM = intrude;
            end else begin
                D_REQ = REQ_NONE;
            end
            D_DIN = (k < wbuf.size()) ? wbuf[k] : '0;
            if (D_BUSY) busy_cyc++;
            if (D_W) begin
                if (k < wbuf.size()) model_mem[(blk0 + k) % DEPTH] = wbuf[k];
                k++;
            end
            if (D_DOUTEN) begin
                pulses++;
                if (first < 0) first = cyc;
                if (exp_q.size() > 0) check({name, " data"}, D_DOUT, exp_q.pop_front());
            end
            if (!D_BUSY) done = 1;
            if (cyc >= budget && !done) begin
                n_tests++; n_fail++;
                $display("FAIL %s timeout: still busy after %0d cycles, expected idle", name, cyc);
                done = 1;
            end
        end
        check({name, " pulses"}, pulses, exp_pulses);
        check({name, " writes"}, k, exp_dw);
`ifdef DRAM_STALL_EN
        check_min({name, " busy"}, busy_cyc, exp_busy);
        if (elem == 64) check_min({name, " stalled"}, busy_cyc, 65);
`else
        check({name, " busy"}, busy_cyc, exp_busy);
        if (op == REQ_READ && elem > 0) check({name, " latency"}, first, 1 + LAT);
`endif
    endtask

    task automatic fill_wbuf(input logic [1:0] op, input int elem, input logic [31:0] base, input bit rnd);
        wbuf.delete();
        if (op == REQ_WRITE) begin
            for (int j = 0; j < elem; j++) wbuf.push_back(rnd ? $urandom : base + j);
        end
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs [13];
    int   dout_cnt;

    initial begin
        vecs[0]  = '{REQ_WRITE, 32'h0,               16, 32'hA0,   0,  16, 16,       0};
        vecs[1]  = '{REQ_WRITE, 32'h0,               4,  32'h1,    0,  4,  4,        0};
        vecs[2]  = '{REQ_READ,  32'h0,               4,  32'h0,    4,  0,  4 + LAT,  0};
        vecs[3]  = '{REQ_WRITE, (DEPTH - 1) * STEP,  3,  32'h100,  0,  3,  3,        0};
        vecs[4]  = '{REQ_READ,  (DEPTH - 1) * STEP,  3,  32'h0,    3,  0,  3 + LAT,  0};
        vecs[5]  = '{REQ_READ,  32'h0,               0,  32'h0,    0,  0,  0,        0};
        vecs[6]  = '{REQ_WRITE, 32'h40,              0,  32'h0,    0,  0,  0,        0};
        vecs[7]  = '{REQ_WRITE, 32'h83,              2,  32'h200,  0,  2,  2,        0};
        vecs[8]  = '{REQ_READ,  32'h7F,              4,  32'h0,    4,  0,  4 + LAT,  0};
        vecs[9]  = '{REQ_READ,  32'h0,               5,  32'h0,    5,  0,  5 + LAT,  7};
        vecs[10] = '{REQ_WRITE, 32'h0,               64, 32'h1000, 0,  64, 64,       0};
        vecs[11] = '{REQ_READ,  32'h0,               64, 32'h0,    64, 0,  64 + LAT, 0};
        vecs[12] = '{2'b11,     32'h0,               4,  32'h0,    0,  0,  0,        0};

        RST = 1'b1; D_REQ = REQ_NONE; D_INITADR = '0; D_ELEM = '0; D_DIN = '0;
        repeat (3) @(negedge CLK);
        check("rst d_w", D_W, 1'b0);
        check("rst douten", D_DOUTEN, 1'b0);
        check("rst dout", D_DOUT, '0);
        check("rst busy", D_BUSY, 1'b0);
        check("rst state", 32'(dbg_state), 32'(ST_IDLE));
        RST = 1'b0;

        for (int i = 0; i < 13; i++) begin
            fill_wbuf(vecs[i].op, vecs[i].elem, vecs[i].base, 1'b0);
            do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].elem,
                   vecs[i].exp_pulses, vecs[i].exp_dw, vecs[i].exp_busy, vecs[i].intrude);
        end

        // Reset two cycles into a 16-block read must flush everything.
        @(negedge CLK);
        D_REQ = REQ_READ; D_INITADR = 32'h0; D_ELEM = 16;
        @(negedge CLK);
        D_REQ = REQ_NONE;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort douten", D_DOUTEN, 1'b0);
        check("abort busy", D_BUSY, 1'b0);
        check("abort dout", D_DOUT, '0);
        dout_cnt = 0;
        repeat (24) begin
            @(negedge CLK);
            if (D_DOUTEN) dout_cnt++;
        end
        check("abort stale pulses", dout_cnt, 0);

        fill_wbuf(REQ_READ, 6, 32'h0, 1'b0);
        do_req("post_rst_read", REQ_READ, 32'h0, 6, 6, 0, 6 + LAT, 0);

        for (int i = 0; i < 30; i++) begin
            logic [1:0]  op;
            logic [31:0] addr;
            int          elem;
            op   = ($urandom_range(0, 1) == 0) ? REQ_READ : REQ_WRITE;
            addr = $urandom;
            elem = $urandom_range(1, 20);
            fill_wbuf(op, elem, 32'h0, 1'b1);
            do_req($sformatf("rnd%0d", i), op, addr, elem,
                   (op == REQ_READ) ? elem : 0, (op == REQ_WRITE) ? elem : 0,
                   (op == REQ_READ) ? elem + LAT : elem, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dram_sim_model.md
DRAM_SIM_MODEL -- requirements
Module: dram_sim_model

Interface
REQ-001 Parameter DRAMW, default 512, data word width in bits.
REQ-002 Parameter DEPTH, default 1048576, number of DRAMW-wide blocks stored.
REQ-003 Parameter ADDR_STEP, default 8, byte-address increment per block.
REQ-004 Parameter RD_LAT, default 4, read latency in cycles from address issue to D_DOUTEN, range 1..16.
REQ-005 Parameter STALL_TH, default 4, stall threshold 0..15, used only under DRAM_STALL_EN.
REQ-006 Parameter LFSR_SEED, default 16'hACE1, nonzero stall-generator seed.
REQ-007 CLK  input  1  clock; all state updates on rising edge.
REQ-008 RST  input  1  reset, synchronous, active-high.
REQ-009 D_REQ  input  2  request: 2'b00 none, 2'b01 read, 2'b10 write, 2'b11 ignored.
REQ-010 D_INITADR  input  32  initial byte address, sampled with request.
REQ-011 D_ELEM  input  32  number of blocks to transfer, sampled with request.
REQ-012 D_DIN  input  DRAMW  write data, consumed in cycles where D_W=1.
REQ-013 D_W  output  1  write strobe: D_DIN accepted this cycle.
REQ-014 D_DOUT  output  DRAMW  read data.
REQ-015 D_DOUTEN  output  1  D_DOUT valid this cycle.
REQ-016 D_BUSY  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, READ, WRITE, DRAIN; D_REQ is sampled only in IDLE.
REQ-018 IDLE + read with D_ELEM>0 -> READ; write with D_ELEM>0 -> WRITE; D_ELEM=0 or none -> stay IDLE.
REQ-019 Block index = (addr / ADDR_STEP) mod DEPTH; address after last block (DEPTH-1)*ADDR_STEP wraps to 0.
REQ-020 WRITE: each unstalled cycle D_W=1 combinationally, D_DIN stored at current address, address advances, remaining decrements.
REQ-021 WRITE: after the D_W cycle with remaining=1, next state IDLE; exactly D_ELEM blocks written.
REQ-022 READ: each unstalled cycle one address issued into an RD_LAT-deep valid/data shift pipeline; after last issue, state DRAIN.
REQ-023 DRAIN: holds until last datum exits; then IDLE; D_BUSY deasserts the cycle after the final D_DOUTEN.
REQ-024 Read data returns in issue order, one block per D_DOUTEN pulse, exactly D_ELEM pulses per request.
REQ-025 Read of a location returns the value of the most recent completed write; never-written locations return X in simulation.
REQ-026 Requests presented while D_BUSY=1 are ignored, not queued.

Reset
REQ-027 RST: state IDLE, D_W=0, D_DOUTEN=0, D_DOUT=0, D_BUSY=0, pipeline valids cleared, counters 0, LFSR=LFSR_SEED.
REQ-028 RST mid-transfer aborts it; in-flight read data is discarded; memory contents retained.

Configuration
REQ-029 Macro DRAM_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) steps every cycle; cycle stalled when lfsr[3:0] < STALL_TH.
REQ-030 Stalled cycle: no D_W, no read issue; pipeline still advances.
REQ-031 Macro undefined: no LFSR, never stalled, one block per cycle in READ/WRITE.

Structure
REQ-032 Shared package holds REQ_NONE/REQ_READ/REQ_WRITE encodings and the FSM state typedef.
REQ-033 One sub-module dram_rd_pipe: RD_LAT-stage valid/data delay line with synchronous clear.

Verification
REQ-034 Write 4 blocks at 0x0 with data 1..4, then read 4 at 0x0 -> D_DOUTEN pulses carry 1,2,3,4; first pulse RD_LAT cycles after first issue.
REQ-035 Write 3 blocks at (DEPTH-1)*8 -> blocks DEPTH-1, 0, 1 written; read back matches.
REQ-036 Read with D_ELEM=0 -> D_BUSY stays 0, no D_DOUTEN.
REQ-037 Assert RST 2 cycles into a 16-block read -> D_DOUTEN=0 and D_BUSY=0 the cycle after RST; no stale data afterward.
REQ-038 DRAM_STALL_EN, STALL_TH=8, 64-block write+read -> exactly 64 D_W and 64 D_DOUTEN, data in order, total cycles >64.
REQ-039 Read request asserted while busy -> ignored; D_DOUTEN count equals first request's D_ELEM only.
